// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and constants for the 4-source round-robin mux arbiter.
// Holds the FSM encoding, source count, select width and a one-hot helper.
package mux4_rr_arbiter_pkg;

  localparam int N_SRC = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [N_SRC-1:0] onehot4(
    input logic [SEL_W-1:0] i
  );
    return 4'b0001 << i;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Handshake bundle between requesters/consumer and the arbiter.
// master: drives req/done, observes gnt/sel/busy; slave: the arbiter side.
interface mux4_rr_arbiter_if
  import mux4_rr_arbiter_pkg::*;
();

  logic [N_SRC-1:0] req;
  logic             done;
  logic [N_SRC-1:0] gnt;
  logic [SEL_W-1:0] sel;
  logic             busy;

  modport master (
    output req,
    output done,
    input  gnt,
    input  sel,
    input  busy
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output sel,
    output busy
  );

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set req bit scanning up from last+1.
// Ports: req[3:0], last[1:0] in; found, idx[1:0] out.
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Scan from lowest priority (last) to highest (last+1) so the
  // highest-priority hit is the one left standing.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      cand = last + 2'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select of an external 4:1 mux.
// Ports: clk, rst_n (async low), bus (slave: req, done -> gnt, sel, busy).
// Option: define ARB_TIMEOUT_EN to force release after HOLD_MAX cycles.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  mux4_rr_arbiter_if.slave  bus
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_range
    $error("HOLD_MAX must be 1..255");
  end

  state_t           state_q, state_d;
  logic [N_SRC-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic             busy_q, busy_d;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             rel;

`ifdef ARB_TIMEOUT_EN
  logic [7:0]       hold_q, hold_d;
`endif

  rr_pick4 u_pick (
    .req   (bus.req),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    busy_d  = busy_q;
    rel     = bus.done || !bus.req[sel_q];
`ifdef ARB_TIMEOUT_EN
    hold_d  = '0;
    rel     = rel || (hold_q == 8'(HOLD_MAX - 1));
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          gnt_d   = onehot4(pick_idx);
          sel_d   = pick_idx;
          busy_d  = 1'b1;
        end
      end
      GRANT: begin
`ifdef ARB_TIMEOUT_EN
        hold_d = hold_q + 8'd1;
`endif
        if (rel) begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          last_d  = sel_q;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      // last=3 makes source 0 the first winner
      last_q  <= 2'd3;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed + model-checked random bench for mux4_rr_arbiter.
// Honours ARB_TIMEOUT_EN (HOLD_MAX=4 in this bench).
module tb_mux4_rr_arbiter;

  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mux4_rr_arbiter_if bus ();

  mux4_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic out(
    input string    tag,
    input bit [3:0] g,
    input bit [1:0] s,
    input bit       b
  );
    chk(tag, {25'd0, bus.gnt, bus.sel, bus.busy}, {25'd0, g, s, b});
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  // reference model state
  bit [3:0] m_gnt;
  bit [1:0] m_sel;
  bit [1:0] m_last;
  bit       m_busy;
  int       m_hold;
  int       wait_n [4];
  int       max_wait;

  task automatic model_edge(input bit [3:0] r, input bit d);
    bit       rel;
    bit [1:0] w;
    if (!m_busy) begin
      if (r != 4'd0) begin
        w = m_last;
        do w = w + 2'd1; while (!r[w]);
        for (int i = 0; i < 4; i++) begin
          if (!r[i] || i == int'(w)) wait_n[i] = 0;
          else wait_n[i]++;
          if (wait_n[i] > max_wait) max_wait = wait_n[i];
        end
        m_busy = 1'b1;
        m_gnt  = 4'd0;
        m_gnt[w] = 1'b1;
        m_sel  = w;
        m_hold = 0;
      end
    end else begin
      rel = d || !r[m_sel];
`ifdef ARB_TIMEOUT_EN
      if (m_hold == HOLD - 1) rel = 1'b1;
      m_hold++;
`endif
      if (rel) begin
        m_busy = 1'b0;
        m_gnt  = 4'd0;
        m_last = m_sel;
      end
    end
  endtask

  initial begin
    bit [3:0] g;
    bus.req  = 4'd0;
    bus.done = 1'b0;
    #3;
    out("reset", 4'b0000, 2'd0, 1'b0);
    #4 rst_n = 1'b1;

    // single grant then done
    step();
    bus.req = 4'b0001;
    step();
    out("grant0", 4'b0001, 2'd0, 1'b1);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    bus.req  = 4'b0000;
    out("rel0", 4'b0000, 2'd0, 1'b0);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    out("idle_done", 4'b0000, 2'd0, 1'b0);

    // full rotation
    do_reset();
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      g = 4'b0001 << (i % 4);
      out($sformatf("rot%0d", i), g, 2'(i % 4), 1'b1);
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      out($sformatf("rot_idle%0d", i), 4'b0000, 2'(i % 4), 1'b0);
    end

    // request drop while source 2 holds
    step();
    out("pre1", 4'b0010, 2'd1, 1'b1);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    step();
    out("grant2", 4'b0100, 2'd2, 1'b1);
    step();
    out("hold2", 4'b0100, 2'd2, 1'b1);
    bus.req = 4'b1011;
    step();
    out("drop2", 4'b0000, 2'd2, 1'b0);
    step();
    out("grant3", 4'b1000, 2'd3, 1'b1);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    step();
    out("grant0b", 4'b0001, 2'd0, 1'b1);

    // async reset mid-grant to source 3
    bus.req = 4'b1000;
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    step();
    out("grant3b", 4'b1000, 2'd3, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    out("async_rst", 4'b0000, 2'd0, 1'b0);
    bus.req = 4'b1001;
    #2 rst_n = 1'b1;
    step();
    out("post_rst", 4'b0001, 2'd0, 1'b1);

`ifdef ARB_TIMEOUT_EN
    do_reset();
    bus.req = 4'b0010;
    step();
    for (int i = 0; i < HOLD; i++) begin
      out($sformatf("to_hold%0d", i), 4'b0010, 2'd1, 1'b1);
      step();
    end
    out("to_idle", 4'b0000, 2'd1, 1'b0);
    step();
    out("to_regrant", 4'b0010, 2'd1, 1'b1);
`endif

    // random traffic against the model
    bus.req  = 4'd0;
    bus.done = 1'b0;
    do_reset();
    m_gnt = 4'd0; m_sel = 2'd0; m_last = 2'd3; m_busy = 1'b0;
    m_hold = 0; max_wait = 0;
    for (int i = 0; i < 4; i++) wait_n[i] = 0;
    for (int c = 0; c < 2000; c++) begin
      bus.req  = 4'($urandom_range(0, 15) | $urandom_range(0, 15));
      bus.done = ($urandom_range(0, 3) == 0);
      model_edge(bus.req, bus.done);
      step();
      out($sformatf("rnd%0d", c), m_gnt, m_sel, m_busy);
      chk("onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
      if (bus.gnt != 4'd0)
        chk("sel_enc", 32'(bus.gnt), 32'(4'b0001 << bus.sel));
    end
    chk("starve", 32'(max_wait <= 3), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
